// File: rtl/alu_pkg.sv
// Types and constants shared by operand fetch, the ALU and the write-back stage.
package alu_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int CNT_W = 16;
  localparam int IMM_W = 32;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [3:0] {
    OP_NOTHING = 4'd0,
    OP_ADD     = 4'd1,
    OP_SUB     = 4'd2,
    OP_MUL     = 4'd3,
    OP_DIV     = 4'd4,
    OP_XOR     = 4'd5,
    OP_AND     = 4'd6,
    OP_OR      = 4'd7,
    OP_REM     = 4'd8,
    OP_NOT     = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction-in, write-back and ALU-out signals of the operand fetch stage.
interface operand_fetch_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  alu_op_e          in_op;
  reg_idx_t         in_rd;
  reg_idx_t         in_rs1;
  reg_idx_t         in_rs2;
  logic [IMM_W-1:0] in_imm;
  logic             in_use_imm;

  logic             wb_en;
  reg_idx_t         wb_rd;
  logic [XLEN-1:0]  wb_data;

  alu_op_e          alu_opcode;
  logic [XLEN-1:0]  alu_value1;
  logic [XLEN-1:0]  alu_value2;
  logic [IMM_W-1:0] alu_immediate;
  reg_idx_t         alu_rd;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_use_imm,
    output wb_en, wb_rd, wb_data,
    input  in_ready, alu_opcode, alu_value1, alu_value2, alu_immediate, alu_rd, stall_count
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_use_imm,
    input  wb_en, wb_rd, wb_data,
    output in_ready, alu_opcode, alu_value1, alu_value2, alu_immediate, alu_rd, stall_count
  );

endinterface

// File: rtl/reg_file.sv
// NREGS x XLEN register file: two asynchronous read ports, one write port, x0 fixed at zero.
module reg_file
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  reg_idx_t        rd_addr1,
  input  reg_idx_t        rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  input  logic            wr_en,
  input  reg_idx_t        wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  // x0 has no storage at all; its reads are muxed to zero below.
  logic [XLEN-1:0] regs_reg [1:NREGS-1];

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          regs_reg[gi] <= '0;
        end else if (wr_en && wr_addr == reg_idx_t'(gi)) begin
          regs_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data1 = (rd_addr1 == '0) ? '0 : regs_reg[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : regs_reg[rd_addr2];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage ahead of the ALU: busy-bit hazard check, operand read with
// write-back bypass, and registered ALU operands.
module operand_fetch
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  operand_fetch_if.slave bus
);

  logic             rs1_used, rs2_used, sets_rd;
  logic             haz_rs1, haz_rs2, haz_rd, hazard, accept;
  logic             wb_live;
  logic [XLEN-1:0]  rf_data1, rf_data2, operand1, operand2;
  logic [NREGS-1:0] busy_reg, busy_next;

  fetch_state_e     state_reg;
  alu_op_e          alu_opcode_reg;
  logic [XLEN-1:0]  alu_value1_reg, alu_value2_reg;
  logic [IMM_W-1:0] alu_immediate_reg;
  reg_idx_t         alu_rd_reg;
  logic [CNT_W-1:0] stall_count_reg;

  reg_file u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (bus.in_rs1),
    .rd_addr2 (bus.in_rs2),
    .rd_data1 (rf_data1),
    .rd_data2 (rf_data2),
    .wr_en    (wb_live),
    .wr_addr  (bus.wb_rd),
    .wr_data  (bus.wb_data)
  );

  assign wb_live  = bus.wb_en && (bus.wb_rd != '0);
  assign rs1_used = (bus.in_op != OP_NOTHING);
  assign rs2_used = !bus.in_use_imm && (bus.in_op != OP_NOTHING) && (bus.in_op != OP_NOT);
  assign sets_rd  = (bus.in_rd != '0) && (bus.in_op != OP_NOTHING);

  // A write-back landing this cycle releases its register in time for issue.
  assign haz_rs1 = rs1_used && (bus.in_rs1 != '0) && busy_reg[bus.in_rs1] &&
                   !(bus.wb_en && bus.wb_rd == bus.in_rs1);
  assign haz_rs2 = rs2_used && (bus.in_rs2 != '0) && busy_reg[bus.in_rs2] &&
                   !(bus.wb_en && bus.wb_rd == bus.in_rs2);
  assign haz_rd  = (bus.in_rd != '0) && busy_reg[bus.in_rd] &&
                   !(bus.wb_en && bus.wb_rd == bus.in_rd);

  assign hazard       = haz_rs1 || haz_rs2 || haz_rd;
  assign accept       = bus.in_valid && !hazard;
  assign bus.in_ready = !hazard;

  always_comb begin
    operand1 = rf_data1;
    if (bus.in_rs1 != '0 && bus.wb_en && bus.wb_rd == bus.in_rs1) begin
      operand1 = bus.wb_data;
    end
    operand2 = rf_data2;
    if (bus.in_use_imm) begin
      operand2 = sext_imm(bus.in_imm);
    end else if (bus.in_rs2 != '0 && bus.wb_en && bus.wb_rd == bus.in_rs2) begin
      operand2 = bus.wb_data;
    end
  end

  // Issue set is applied after the write-back clear so it wins on a collision.
  always_comb begin
    busy_next = busy_reg;
    if (wb_live) begin
      busy_next[bus.wb_rd] = 1'b0;
    end
    if (accept && sets_rd) begin
      busy_next[bus.in_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      busy_reg          <= '0;
      alu_opcode_reg    <= OP_NOTHING;
      alu_value1_reg    <= '0;
      alu_value2_reg    <= '0;
      alu_immediate_reg <= '0;
      alu_rd_reg        <= '0;
      stall_count_reg   <= '0;
    end else begin
      busy_reg <= busy_next;

      if (accept) begin
        alu_opcode_reg    <= bus.in_op;
        alu_value1_reg    <= operand1;
        alu_value2_reg    <= operand2;
        alu_immediate_reg <= bus.in_imm;
        alu_rd_reg        <= bus.in_rd;
      end else begin
        alu_opcode_reg    <= OP_NOTHING;
      end

      if (bus.in_valid && hazard && stall_count_reg != '1) begin
        stall_count_reg <= stall_count_reg + 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (accept)                      state_reg <= ST_ISSUE;
          else if (bus.in_valid && hazard) state_reg <= ST_STALL;
        end
        ST_ISSUE: begin
          if (!bus.in_valid)               state_reg <= ST_IDLE;
          else if (accept)                 state_reg <= ST_ISSUE;
          else                             state_reg <= ST_STALL;
        end
        ST_STALL: begin
          if (!bus.in_valid)               state_reg <= ST_IDLE;
          else if (accept)                 state_reg <= ST_ISSUE;
        end
        default:                           state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_opcode    = alu_opcode_reg;
  assign bus.alu_value1    = alu_value1_reg;
  assign bus.alu_value2    = alu_value2_reg;
  assign bus.alu_immediate = alu_immediate_reg;
  assign bus.alu_rd        = alu_rd_reg;
  assign bus.stall_count   = stall_count_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a reference model predicts ready, operands and stalls.
module tb_operand_fetch;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] v1;
    logic [63:0] v2;
    logic [31:0] imm;
    logic [4:0]  rd;
  } exp_t;

  localparam int ADD = 1;
  localparam int SUB = 2;
  localparam int NOT = 9;

  logic clk;
  logic reset;
  operand_fetch_if bus();

  operand_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb_q[$];
  exp_t        last_exp;
  logic [63:0] m_regs[32];
  logic        m_busy[32];
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt    = '0;
    last_exp = '0;
    sb_q.delete();
  endtask

  // Called at a negedge: drive one cycle, predict, clock it, compare at the next negedge.
  task automatic step(input logic v, input int op, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input logic ui,
                      input logic we, input int wrd, input logic [63:0] wd);
    logic        haz;
    logic        acc;
    logic [63:0] v1;
    logic [63:0] v2;
    exp_t        e;
    bus.in_valid   = v;
    bus.in_op      = alu_op_e'(4'(op));
    bus.in_rd      = 5'(rd);
    bus.in_rs1     = 5'(rs1);
    bus.in_rs2     = 5'(rs2);
    bus.in_imm     = imm;
    bus.in_use_imm = ui;
    bus.wb_en      = we;
    bus.wb_rd      = 5'(wrd);
    bus.wb_data    = wd;
    #1;
    haz = 1'b0;
    if (op != 0 && rs1 != 0 && m_busy[rs1] && !(we && wrd == rs1)) haz = 1'b1;
    if (!ui && op != 0 && op != NOT && rs2 != 0 && m_busy[rs2] && !(we && wrd == rs2)) haz = 1'b1;
    if (rd != 0 && m_busy[rd] && !(we && wrd == rd)) haz = 1'b1;
    check("in_ready", 64'(bus.in_ready), 64'(!haz));
    acc = v && !haz;
    v1 = (rs1 == 0) ? 64'd0 : (we && wrd == rs1) ? wd : m_regs[rs1];
    if (ui)                    v2 = {{32{imm[31]}}, imm};
    else if (rs2 == 0)         v2 = 64'd0;
    else if (we && wrd == rs2) v2 = wd;
    else                       v2 = m_regs[rs2];
    if (acc) sb_q.push_back({4'(op), v1, v2, imm, 5'(rd)});
    if (v && haz && m_cnt != 16'hFFFF) m_cnt++;
    if (we && wrd != 0) begin
      m_regs[wrd] = wd;
      m_busy[wrd] = 1'b0;
    end
    if (acc && rd != 0 && op != 0) m_busy[rd] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      e        = sb_q.pop_front();
      last_exp = e;
      $display("issue op=%0d rd=%0d value1=%h value2=%h imm=%h", e.op, e.rd, e.v1, e.v2, e.imm);
    end else begin
      e    = last_exp;
      e.op = 4'd0;
    end
    check("alu_opcode", 64'(bus.alu_opcode), 64'(e.op));
    check("alu_value1", bus.alu_value1, e.v1);
    check("alu_value2", bus.alu_value2, e.v2);
    check("alu_immediate", 64'(bus.alu_immediate), 64'(e.imm));
    check("alu_rd", 64'(bus.alu_rd), 64'(e.rd));
    check("stall_count", 64'(bus.stall_count), 64'(m_cnt));
  endtask

  task automatic wb(input int rd, input logic [63:0] data);
    step(1'b0, 0, 0, 0, 0, 32'd0, 1'b0, 1'b1, rd, data);
  endtask

  task automatic iss(input int op, input int rd, input int rs1, input int rs2);
    step(1'b1, op, rd, rs1, rs2, 32'd0, 1'b0, 1'b0, 0, 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_opcode"}, 64'(bus.alu_opcode), 64'd0);
    check({tag, "_value1"}, bus.alu_value1, 64'd0);
    check({tag, "_value2"}, bus.alu_value2, 64'd0);
    check({tag, "_imm"}, 64'(bus.alu_immediate), 64'd0);
    check({tag, "_rd"}, 64'(bus.alu_rd), 64'd0);
    check({tag, "_stall"}, 64'(bus.stall_count), 64'd0);
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_op      = OP_NOTHING;
    bus.in_rd      = '0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_imm     = '0;
    bus.in_use_imm = 1'b0;
    bus.wb_en      = 1'b0;
    bus.wb_rd      = '0;
    bus.wb_data    = '0;
    model_clear();
    #7;
    check_reset_state("reset");
    #1 reset = 1'b0;
    @(negedge clk);

    // Basic issue
    wb(1, 64'd5);
    wb(2, 64'd7);
    iss(ADD, 3, 1, 2);
    check("t1_value1", bus.alu_value1, 64'd5);
    check("t1_value2", bus.alu_value2, 64'd7);

    // RAW stall released by a same-cycle write-back
    wb(3, 64'h100);
    iss(ADD, 3, 1, 2);
    repeat (3) iss(SUB, 8, 3, 2);
    check("t2_stall_count", 64'(bus.stall_count), 64'd3);
    step(1'b1, SUB, 8, 3, 2, 32'd0, 1'b0, 1'b1, 3, 64'd12);
    check("t2_bypass", bus.alu_value1, 64'd12);

    // Sign-extended immediate
    step(1'b1, ADD, 9, 1, 0, 32'hFFFF_FFFC, 1'b1, 1'b0, 0, 64'd0);
    check("t3_value2", bus.alu_value2, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t3_imm", 64'(bus.alu_immediate), 64'h0000_0000_FFFF_FFFC);

    // x0 handling and unused rs2 of busy x8
    wb(0, 64'd99);
    iss(ADD, 10, 0, 0);
    check("t4_x0", bus.alu_value1, 64'd0);
    iss(ADD, 0, 1, 2);
    iss(ADD, 0, 1, 2);
    iss(NOT, 11, 1, 8);
    step(1'b1, ADD, 14, 1, 8, 32'd3, 1'b1, 1'b0, 0, 64'd0);
    iss(ADD, 15, 1, 8);

    // Issue set beats write-back clear on the same register
    wb(8, 64'd88);
    iss(ADD, 4, 1, 2);
    step(1'b1, ADD, 4, 1, 2, 32'd0, 1'b0, 1'b1, 4, 64'd44);
    repeat (2) iss(ADD, 12, 4, 0);
    check("t5_ready", 64'(bus.in_ready), 64'd0);

    // Asynchronous reset in the middle of a stall
    #1 reset = 1'b1;
    #1 check_reset_state("midreset");
    bus.in_valid = 1'b0;
    #1 reset = 1'b0;
    model_clear();
    @(negedge clk);

    // Saturating stall counter
    iss(ADD, 7, 1, 2);
    for (int i = 0; i < 70000; i++) iss(SUB, 13, 7, 0);
    check("t6_saturate", 64'(bus.stall_count), 64'hFFFF);
    step(1'b1, SUB, 13, 7, 0, 32'd0, 1'b0, 1'b1, 7, 64'd21);
    check("t6_release", bus.alu_value1, 64'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
